// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Groups the signals between the multicycle ARM-subset controller and its
// datapath. The datapath drives the instruction fields and ALU flags. The
// controller drives the enables and selects.
//   master : datapath side (drives Cond/Op/Funct/Rd/ALUFlags[/mem_ready])
//   slave  : controller side (drives PCWrite..ALUControl)
// mem_ready exists only when MEM_WAIT_EN is defined.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
`ifdef MEM_WAIT_EN
   logic       mem_ready;
`endif
   logic       PCWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       IRWrite;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [1:0] ALUControl;

   modport master (
`ifdef MEM_WAIT_EN
      output mem_ready,
`endif
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
      input  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
   );

   modport slave (
`ifdef MEM_WAIT_EN
      input  mem_ready,
`endif
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
      output ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore-style control unit for a multicycle ARM-subset processor: main FSM,
// ALU decoder, condition check and the NZCV flags register.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - multicycle_ctrl_if.slave (instruction fields and ALU flags in,
//           datapath enables and selects out)
// Optional feature: define MEM_WAIT_EN to add bus.mem_ready. FETCH, MEMREAD
// and MEMWRITE then stall until memory is ready. IRWrite, PCWrite and
// MemWrite are held low while the controller is stalled.
//
// state      | meaning
// -----------+----------------------------------------------
// FETCH      | read instruction, PC <= PC+4
// DECODE     | read registers, latch condition result
// MEMADR     | compute load/store address
// MEMREAD    | read data memory
// MEMWB      | write loaded data to the register file
// MEMWRITE   | write data memory
// EXECUTER   | ALU op with register operand
// EXECUTEI   | ALU op with immediate operand
// ALUWB      | write ALU result to the register file
// BRANCH     | PC <= branch target
// (10..15)   | unused codes, return to FETCH
// ---------------------------------------------------------------------------
module multicycle_ctrl (
   input  logic               clk,
   input  logic               reset,
   multicycle_ctrl_if.slave   bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   typedef struct packed {
      logic       next_pc;
      logic       ir_write;
      logic       mem_w;
      logic       reg_w;
      logic       branch;
      logic       alu_op;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
   } ctrl_t;

   function automatic ctrl_t decode_state(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.next_pc    = 1'b1;
            c.ir_write   = 1'b1;
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_DECODE: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_MEMADR:   c.alu_src_b = 2'b01;
         S_MEMREAD:  c.adr_src   = 1'b1;
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_w      = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src = 1'b1;
            c.mem_w   = 1'b1;
         end
         S_EXECUTER: c.alu_op = 1'b1;
         S_EXECUTEI: begin
            c.alu_src_b = 2'b01;
            c.alu_op    = 1'b1;
         end
         S_ALUWB:    c.reg_w = 1'b1;
         S_BRANCH: begin
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.branch     = 1'b1;
         end
         default:    c = '0;
      endcase
      return c;
   endfunction

   // flags are {N,Z,C,V}
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, cf, v;
      logic r;
      {n, z, cf, v} = f;
      case (cond)
         4'b0000: r = z;
         4'b0001: r = ~z;
         4'b0010: r = cf;
         4'b0011: r = ~cf;
         4'b0100: r = n;
         4'b0101: r = ~n;
         4'b0110: r = v;
         4'b0111: r = ~v;
         4'b1000: r = cf & ~z;
         4'b1001: r = ~cf | z;
         4'b1010: r = (n == v);
         4'b1011: r = (n != v);
         4'b1100: r = ~z & (n == v);
         4'b1101: r = z | (n != v);
         4'b1110: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   state_t     state_q, state_d;
   ctrl_t      ctrl_q;
   logic [3:0] flags_q, flags_d;
   logic       cond_q, cond_d;
   logic [1:0] alu_ctrl;
   logic       mem_go;
   logic       pcs;

   // mem_go is low only while a memory-facing state waits on the memory
`ifdef MEM_WAIT_EN
   logic wait_st;
   assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);
   assign mem_go  = ~wait_st | bus.mem_ready;
`else
   assign mem_go  = 1'b1;
`endif

   always_comb begin
      alu_ctrl = 2'b00;
      if (ctrl_q.alu_op) begin
         case (bus.Funct[4:1])
            4'b0100: alu_ctrl = 2'b00;
            4'b0010: alu_ctrl = 2'b01;
            4'b0000: alu_ctrl = 2'b10;
            4'b1100: alu_ctrl = 2'b11;
            default: alu_ctrl = 2'b00;
         endcase
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
      if (!mem_go) state_d = state_q;
   end

   // C and V only come from the adder, so logic ops update N/Z alone
   always_comb begin
      flags_d = flags_q;
      cond_d  = cond_q;
      if (state_q == S_DECODE) cond_d = cond_pass(bus.Cond, flags_q);
      if (((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) && cond_q && bus.Funct[0]) begin
         flags_d[3:2] = bus.ALUFlags[3:2];
         if (!alu_ctrl[1]) flags_d[1:0] = bus.ALUFlags[1:0];
      end
   end

   // ctrl_q always equals decode_state(state_q), so the Moore outputs come
   // straight from flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         ctrl_q  <= decode_state(S_FETCH);
         flags_q <= 4'b0000;
         cond_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode_state(state_d);
         flags_q <= flags_d;
         cond_q  <= cond_d;
      end
   end

   assign pcs            = ctrl_q.branch | (ctrl_q.reg_w & (bus.Rd == 4'hF));
   assign bus.PCWrite    = (ctrl_q.next_pc | (pcs & cond_q)) & mem_go;
   assign bus.IRWrite    = ctrl_q.ir_write & mem_go;
   assign bus.RegWrite   = ctrl_q.reg_w & cond_q;
   assign bus.MemWrite   = ctrl_q.mem_w & cond_q & mem_go;
   assign bus.AdrSrc     = ctrl_q.adr_src;
   assign bus.ALUSrcA    = ctrl_q.alu_src_a;
   assign bus.ALUSrcB    = ctrl_q.alu_src_b;
   assign bus.ResultSrc  = ctrl_q.result_src;
   assign bus.ALUControl = alu_ctrl;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

   localparam logic [3:0] FE  = 4'd0;
   localparam logic [3:0] DE  = 4'd1;
   localparam logic [3:0] MA  = 4'd2;
   localparam logic [3:0] MR  = 4'd3;
   localparam logic [3:0] MWB = 4'd4;
   localparam logic [3:0] MW  = 4'd5;
   localparam logic [3:0] XR  = 4'd6;
   localparam logic [3:0] XI  = 4'd7;
   localparam logic [3:0] AW  = 4'd8;
   localparam logic [3:0] BR  = 4'd9;

   typedef struct packed {
      logic [3:0] st;
      logic       cond;
      logic [3:0] flags;
      logic       pcw, rw, mw, irw, adr, srca;
      logic [1:0] srcb, res, aluc, imm, regsrc;
   } rec_t;

   typedef struct packed {
      logic       nextpc, irw, srca, adr, memw, regw, branch;
      logic [1:0] srcb, res;
   } raw_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_ctrl_if bus();
   multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   rec_t exp_q[$];
   int   id_q[$];
   int   rec_id = 0;
   int   n_total = 0;
   int   n_bad = 0;
   logic       cur_cond = 1'b0;
   logic [3:0] cur_flags = 4'h0;
   event sample_ev;

   function automatic raw_t raw_of(input logic [3:0] s);
      raw_t r;
      r = '0;
      case (s)
         FE:  begin r.nextpc = 1'b1; r.irw = 1'b1; r.srca = 1'b1; r.srcb = 2'b10; r.res = 2'b10; end
         DE:  begin r.srca = 1'b1; r.srcb = 2'b10; r.res = 2'b10; end
         MA:  r.srcb = 2'b01;
         MR:  r.adr = 1'b1;
         MW:  begin r.adr = 1'b1; r.memw = 1'b1; end
         MWB: begin r.res = 2'b01; r.regw = 1'b1; end
         XI:  r.srcb = 2'b01;
         AW:  r.regw = 1'b1;
         BR:  begin r.srcb = 2'b01; r.res = 2'b10; r.branch = 1'b1; end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic rec_t mk_rec(input logic [3:0] s, input logic c, input logic [3:0] fl,
                                   input logic [1:0] aluc, input logic [1:0] op, input logic [3:0] rd);
      raw_t w;
      rec_t r;
      logic pcs;
      w = raw_of(s);
      pcs = w.branch | (w.regw & (rd == 4'hF));
      r.st = s;
      r.cond = c;
      r.flags = fl;
      r.pcw = w.nextpc | (pcs & c);
      r.rw = w.regw & c;
      r.mw = w.memw & c;
      r.irw = w.irw;
      r.adr = w.adr;
      r.srca = w.srca;
      r.srcb = w.srcb;
      r.res = w.res;
      r.aluc = (s == XR || s == XI) ? aluc : 2'b00;
      r.imm = op;
      r.regsrc = {op == 2'b01, op == 2'b10};
      return r;
   endfunction

   function automatic rec_t sample();
      rec_t r;
      r.st = dut.state_q;
      r.cond = dut.cond_q;
      r.flags = dut.flags_q;
      r.pcw = bus.PCWrite;
      r.rw = bus.RegWrite;
      r.mw = bus.MemWrite;
      r.irw = bus.IRWrite;
      r.adr = bus.AdrSrc;
      r.srca = bus.ALUSrcA;
      r.srcb = bus.ALUSrcB;
      r.res = bus.ResultSrc;
      r.aluc = bus.ALUControl;
      r.imm = bus.ImmSrc;
      r.regsrc = bus.RegSrc;
      return r;
   endfunction

   task automatic push(input rec_t r);
      exp_q.push_back(r);
      id_q.push_back(rec_id);
      rec_id++;
   endtask

   // Drive one instruction and queue the expected record of each cycle.
   // ec: condition result latched in DECODE; fa: flags after execute.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                            input logic [3:0] rd, input logic [3:0] af, input logic ec,
                            input logic [1:0] aluc, input logic [3:0] fa,
                            input int nst, input logic [19:0] seq);
      logic [3:0] s;
      logic       cn;
      logic [3:0] fl;
      bus.Cond = c;
      bus.Op = op;
      bus.Funct = fn;
      bus.Rd = rd;
      bus.ALUFlags = af;
      for (int i = 0; i < nst; i++) begin
         s  = seq[4*i +: 4];
         cn = (s == FE || s == DE) ? cur_cond : ec;
         fl = (s == AW) ? fa : cur_flags;
         push(mk_rec(s, cn, fl, aluc, op, rd));
         @(posedge clk); #1;
      end
      cur_cond = ec;
      cur_flags = fa;
   endtask

   initial begin : monitor
      rec_t e, o;
      int   id;
      forever begin
         @(negedge clk or sample_ev);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            id = id_q.pop_front();
            o = sample();
            n_total++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL rec%0d state=%0d: got=%h want=%h", id, e.st, o, e);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rec_t r;
      reset = 1'b0;
      bus.Cond = 4'hE;
      bus.Op = 2'b00;
      bus.Funct = 6'd0;
      bus.Rd = 4'd0;
      bus.ALUFlags = 4'd0;
`ifdef MEM_WAIT_EN
      bus.mem_ready = 1'b1;
`endif
      @(posedge clk); #1;
      push(mk_rec(FE, 1'b0, 4'h0, 2'b00, 2'b00, 4'd0));
      @(posedge clk); #1;
      reset = 1'b1;

      // ADD R2,R0,#5 (S=0: ALUFlags ignored)
      run_instr(4'hE, 2'b00, 6'b101000, 4'd2, 4'hF, 1'b1, 2'b00, 4'h0, 4, {4'd0, AW, XI, DE, FE});
      // SUBS Z=1, then BEQ taken
      run_instr(4'hE, 2'b00, 6'b100101, 4'd1, 4'b0100, 1'b1, 2'b01, 4'b0100, 4, {4'd0, AW, XI, DE, FE});
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, 2'b00, 4'b0100, 3, {8'd0, BR, DE, FE});
      // SUBS Z=0, then BEQ not taken
      run_instr(4'hE, 2'b00, 6'b100101, 4'd1, 4'b0000, 1'b1, 2'b01, 4'b0000, 4, {4'd0, AW, XI, DE, FE});
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b0, 2'b00, 4'b0000, 3, {8'd0, BR, DE, FE});
      // LDR, STR
      run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0, 1'b1, 2'b00, 4'h0, 5, {MWB, MR, MA, DE, FE});
      run_instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b1, 2'b00, 4'h0, 4, {4'd0, MW, MA, DE, FE});
      // AND PC,... (register form, Rd=15)
      run_instr(4'hE, 2'b00, 6'b000000, 4'hF, 4'hF, 1'b1, 2'b10, 4'h0, 4, {4'd0, AW, XR, DE, FE});
      // ORRS: N/Z load, C/V kept
      run_instr(4'hE, 2'b00, 6'b111001, 4'd4, 4'b1011, 1'b1, 2'b11, 4'b1000, 4, {4'd0, AW, XI, DE, FE});
      // ADDSEQ PC with Z=0: no write, no flag load
      run_instr(4'h0, 2'b00, 6'b101001, 4'hF, 4'b0100, 1'b0, 2'b00, 4'b1000, 4, {4'd0, AW, XI, DE, FE});
      // Op=11 returns to FETCH after DECODE
      run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, 1'b1, 2'b00, 4'b1000, 2, {12'd0, DE, FE});
      // LT true (N=1,V=0), GT false
      run_instr(4'hB, 2'b00, 6'b101000, 4'd5, 4'h0, 1'b1, 2'b00, 4'b1000, 4, {4'd0, AW, XI, DE, FE});
      run_instr(4'hC, 2'b00, 6'b101000, 4'd5, 4'h0, 1'b0, 2'b00, 4'b1000, 4, {4'd0, AW, XI, DE, FE});

      // STR interrupted by reset during MEMWRITE
      run_instr(4'hE, 2'b01, 6'b011000, 4'd6, 4'h0, 1'b1, 2'b00, 4'b1000, 3, {8'd0, MA, DE, FE});
      push(mk_rec(MW, 1'b1, 4'b1000, 2'b00, 2'b01, 4'd6));
      @(negedge clk); #1;
      reset = 1'b0;
      #1;
      push(mk_rec(FE, 1'b0, 4'h0, 2'b00, 2'b01, 4'd6));
      -> sample_ev;
      @(posedge clk); #1;
      push(mk_rec(FE, 1'b0, 4'h0, 2'b00, 2'b01, 4'd6));
      @(posedge clk); #1;
      reset = 1'b1;
      cur_cond = 1'b0;
      cur_flags = 4'h0;
      run_instr(4'hE, 2'b00, 6'b101000, 4'd2, 4'h0, 1'b1, 2'b00, 4'h0, 4, {4'd0, AW, XI, DE, FE});

`ifdef MEM_WAIT_EN
      bus.Cond = 4'hE;
      bus.Op = 2'b00;
      bus.Funct = 6'b101000;
      bus.Rd = 4'd2;
      bus.mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         r = mk_rec(FE, cur_cond, cur_flags, 2'b00, 2'b00, 4'd2);
         r.pcw = 1'b0;
         r.irw = 1'b0;
         push(r);
         @(posedge clk); #1;
      end
      bus.mem_ready = 1'b1;
      run_instr(4'hE, 2'b00, 6'b101000, 4'd2, 4'h0, 1'b1, 2'b00, 4'h0, 4, {4'd0, AW, XI, DE, FE});
`endif

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_total++;
         n_bad++;
         $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
